// File: rtl/fir_coeff_loader.sv
// Coefficient writer for systolic FIR filters: collects a tap set into a shadow
// bank over a stream port, then swaps it into the active bank on a ce_i cycle.
module fir_coeff_loader #(
  parameter int                            NTAPS        = 5,
  parameter int                            COEFF_BITS   = 18,
  parameter int                            FLUSH_CYCLES = 10,
  parameter logic [NTAPS*COEFF_BITS-1:0]   INIT_COEFFS  = '0
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic [COEFF_BITS-1:0]         s_tdata_i,
  input  logic                          s_tvalid_i,
  output logic                          s_tready_o,
  input  logic                          s_tlast_i,
  input  logic                          ce_i,
  output logic [NTAPS*COEFF_BITS-1:0]   coeff_o,
  output logic                          update_o,
  output logic                          settling_o,
  output logic                          err_o,
  input  logic                          err_clr_i,
  output logic [2:0]                    state_o
);

  // Handshake: a word transfers on a rising clk_i edge where s_tvalid_i and
  // s_tready_o are both high; s_tready_o never depends on s_tvalid_i.

  localparam int IDXW = (NTAPS > 1) ? $clog2(NTAPS) : 1;
  localparam int CNTW = (FLUSH_CYCLES > 0) ? $clog2(FLUSH_CYCLES + 1) : 1;
  localparam logic [IDXW-1:0] LAST_IDX   = IDXW'(NTAPS - 1);
  localparam logic [CNTW-1:0] FLUSH_LOAD = CNTW'(FLUSH_CYCLES);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    COLLECT = 3'd1,
    DISCARD = 3'd2,
    PENDING = 3'd3,
    SETTLE  = 3'd4
  } state_t;

  state_t                        state_q, state_d;
  logic [IDXW-1:0]               idx_q;
  logic [CNTW-1:0]               cnt_q;
  logic [NTAPS*COEFF_BITS-1:0]   shadow_q;
  logic [NTAPS*COEFF_BITS-1:0]   coeff_q;
  logic                          update_q, settling_q, err_q;

  logic accept;
  logic shadow_we, idx_inc, idx_clr, err_set, apply, cnt_dec;

  assign s_tready_o = !rst_i && (state_q == IDLE || state_q == COLLECT || state_q == DISCARD);
  assign accept     = s_tvalid_i && s_tready_o;

  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    shadow_we = 1'b0;
    idx_inc   = 1'b0;
    idx_clr   = 1'b0;
    err_set   = 1'b0;
    apply     = 1'b0;
    cnt_dec   = 1'b0;
    case (state_q)
      IDLE, COLLECT: begin
        if (accept) begin
          shadow_we = 1'b1;
          if (idx_q == LAST_IDX) begin
            idx_clr = 1'b1;
            if (s_tlast_i) begin
              state_d = PENDING;
            end else begin
              err_set = 1'b1;
              state_d = DISCARD;
            end
          end else if (s_tlast_i) begin
            err_set = 1'b1;
            idx_clr = 1'b1;
            state_d = IDLE;
          end else begin
            idx_inc = 1'b1;
            state_d = COLLECT;
          end
        end
      end
      DISCARD: begin
        if (accept && s_tlast_i) state_d = IDLE;
      end
      PENDING: begin
        if (ce_i) begin
          apply   = 1'b1;
          state_d = (FLUSH_CYCLES == 0) ? IDLE : SETTLE;
        end
      end
      SETTLE: begin
        if (ce_i) begin
          cnt_dec = 1'b1;
          if (cnt_q == CNTW'(1)) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      coeff_q    <= INIT_COEFFS;
      shadow_q   <= '0;
      idx_q      <= '0;
      cnt_q      <= '0;
      update_q   <= 1'b0;
      settling_q <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      update_q <= apply;
      if (shadow_we) shadow_q[idx_q*COEFF_BITS +: COEFF_BITS] <= s_tdata_i;
      if (idx_clr)      idx_q <= '0;
      else if (idx_inc) idx_q <= idx_q + IDXW'(1);
      // The whole bank moves on one edge so the filter never sees a mixed set.
      if (apply) begin
        coeff_q    <= shadow_q;
        settling_q <= (FLUSH_CYCLES != 0);
        cnt_q      <= FLUSH_LOAD;
      end else if (cnt_dec) begin
        cnt_q <= cnt_q - CNTW'(1);
        if (cnt_q == CNTW'(1)) settling_q <= 1'b0;
      end
      if (err_set)        err_q <= 1'b1;
      else if (err_clr_i) err_q <= 1'b0;
    end
  end

  assign coeff_o    = coeff_q;
  assign update_o   = update_q;
  assign settling_o = settling_q;
  assign err_o      = err_q;
  assign state_o    = state_q;

endmodule

// File: tb/tb_fir_coeff_loader.sv
// Directed bench for fir_coeff_loader: a default-flush instance for the main
// scenarios and a zero-flush instance for back-to-back streaming.
module tb_fir_coeff_loader;

  localparam logic [2:0] S_IDLE = 3'd0, S_COLLECT = 3'd1, S_DISCARD = 3'd2,
                         S_PENDING = 3'd3, S_SETTLE = 3'd4;
  localparam logic [89:0] INIT_A = {18'd500, 18'd400, 18'd300, 18'd200, 18'd100};

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [17:0] tdata = '0;
  logic        tvalid = 1'b0, tlast = 1'b0, ce = 1'b1, err_clr = 1'b0;
  logic        tready, update, settling, err;
  logic [89:0] coeff;
  logic [2:0]  state;

  logic [17:0] b_tdata = '0;
  logic        b_tvalid = 1'b0, b_tlast = 1'b0;
  logic        b_tready, b_update, b_settling, b_err;
  logic [89:0] b_coeff;
  logic [2:0]  b_state;

  int n_checks = 0;
  int n_fail   = 0;
  logic [89:0] exp_q[$];

  always #5 clk = ~clk;

  fir_coeff_loader #(.NTAPS(5), .COEFF_BITS(18), .FLUSH_CYCLES(10), .INIT_COEFFS(INIT_A)) dut_a (
    .clk_i(clk), .rst_i(rst), .s_tdata_i(tdata), .s_tvalid_i(tvalid), .s_tready_o(tready),
    .s_tlast_i(tlast), .ce_i(ce), .coeff_o(coeff), .update_o(update), .settling_o(settling),
    .err_o(err), .err_clr_i(err_clr), .state_o(state)
  );

  fir_coeff_loader #(.NTAPS(5), .COEFF_BITS(18), .FLUSH_CYCLES(0), .INIT_COEFFS('0)) dut_b (
    .clk_i(clk), .rst_i(rst), .s_tdata_i(b_tdata), .s_tvalid_i(b_tvalid), .s_tready_o(b_tready),
    .s_tlast_i(b_tlast), .ce_i(1'b1), .coeff_o(b_coeff), .update_o(b_update),
    .settling_o(b_settling), .err_o(b_err), .err_clr_i(1'b0), .state_o(b_state)
  );

  function automatic logic [89:0] pack5(input int t0, input int t1, input int t2,
                                        input int t3, input int t4);
    return {18'(t4), 18'(t3), 18'(t2), 18'(t1), 18'(t0)};
  endfunction

  // Called and returns on a falling edge; the word transfers on the rising edge in between.
  task automatic send_word(input bit sel, input logic [17:0] d, input logic last);
    int n;
    n = 0;
    if (!sel) begin tdata = d; tvalid = 1'b1; tlast = last; end
    else      begin b_tdata = d; b_tvalid = 1'b1; b_tlast = last; end
    while (((sel ? b_tready : tready) !== 1'b1) && n < 100) begin
      @(negedge clk);
      n++;
    end
    n_checks++;
    if ((sel ? b_tready : tready) !== 1'b1) begin
      n_fail++;
      $display("FAIL send_timeout: sel=%0d word %h never accepted (tready stayed low)", sel, d);
    end else begin
      @(negedge clk);
    end
    if (!sel) begin tvalid = 1'b0; tlast = 1'b0; end
    else      begin b_tvalid = 1'b0; b_tlast = 1'b0; end
  endtask

  task automatic send_frame(input int base);
    for (int i = 0; i < 5; i++) send_word(1'b0, 18'(base + i), i == 4);
  endtask

  task automatic wait_update(input string name, input logic [89:0] exp);
    int n;
    n = 0;
    while (update !== 1'b1 && n < 20) begin @(negedge clk); n++; end
    n_checks++;
    if (update !== 1'b1) begin
      n_fail++;
      $display("FAIL %s_update: update_o never pulsed", name);
    end
    n_checks++;
    if (coeff !== exp) begin
      n_fail++;
      $display("FAIL %s_coeff: got %h expected %h", name, coeff, exp);
    end
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while (state !== S_IDLE && n < 200) begin @(negedge clk); n++; end
    n_checks++;
    if (state !== S_IDLE) begin
      n_fail++;
      $display("FAIL %s_idle: state %0d expected %0d", name, state, S_IDLE);
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    n_checks++; if (tready !== 1'b0) begin n_fail++; $display("FAIL reset_tready: got %b expected 0", tready); end
    n_checks++; if (coeff !== INIT_A) begin n_fail++; $display("FAIL reset_coeff: got %h expected %h", coeff, INIT_A); end
    n_checks++; if (b_coeff !== 90'd0) begin n_fail++; $display("FAIL reset_coeff_b: got %h expected 0", b_coeff); end
    n_checks++; if ({update, settling, err} !== 3'b000) begin n_fail++; $display("FAIL reset_flags: got %b expected 000", {update, settling, err}); end
    n_checks++; if (state !== S_IDLE) begin n_fail++; $display("FAIL reset_state: got %0d expected %0d", state, S_IDLE); end
    rst = 1'b0;
    @(negedge clk);
    n_checks++; if (tready !== 1'b1) begin n_fail++; $display("FAIL reset_release_tready: got %b expected 1", tready); end
  endtask

  task automatic test_single_frame();
    logic [89:0] exp;
    int n;
    logic bad_ready, bad_update;
    exp = pack5(1, 2, 3, 4, 5);
    for (int i = 1; i <= 4; i++) send_word(1'b0, 18'(i), 1'b0);
    n_checks++; if (state !== S_COLLECT) begin n_fail++; $display("FAIL single_collect: state %0d expected %0d", state, S_COLLECT); end
    send_word(1'b0, 18'd5, 1'b1);
    n_checks++; if (state !== S_PENDING) begin n_fail++; $display("FAIL single_pending: state %0d expected %0d", state, S_PENDING); end
    n_checks++; if (coeff !== INIT_A) begin n_fail++; $display("FAIL single_early: got %h expected %h", coeff, INIT_A); end
    n_checks++; if (tready !== 1'b0) begin n_fail++; $display("FAIL single_pend_tready: got %b expected 0", tready); end
    @(negedge clk);
    n_checks++; if (coeff !== exp) begin n_fail++; $display("FAIL single_coeff: got %h expected %h", coeff, exp); end
    n_checks++; if (update !== 1'b1) begin n_fail++; $display("FAIL single_update: got %b expected 1", update); end
    n = 0; bad_ready = 1'b0; bad_update = 1'b0;
    while (settling === 1'b1 && n < 50) begin
      if (tready !== 1'b0) bad_ready = 1'b1;
      if (n > 0 && update !== 1'b0) bad_update = 1'b1;
      n++;
      @(negedge clk);
    end
    n_checks++; if (n != 10) begin n_fail++; $display("FAIL single_settle_len: got %0d cycles expected 10", n); end
    n_checks++; if (bad_ready !== 1'b0) begin n_fail++; $display("FAIL single_settle_tready: tready high during settle"); end
    n_checks++; if (bad_update !== 1'b0) begin n_fail++; $display("FAIL single_update_width: update_o longer than one cycle"); end
    n_checks++; if (state !== S_IDLE || tready !== 1'b1) begin n_fail++; $display("FAIL single_return: state %0d tready %b expected 0/1", state, tready); end
  endtask

  task automatic test_ce_gated();
    int c, n;
    ce = 1'b0;
    send_frame(11);
    repeat (5) @(negedge clk);
    n_checks++; if (state !== S_PENDING) begin n_fail++; $display("FAIL ce_hold_state: got %0d expected %0d", state, S_PENDING); end
    n_checks++; if (tready !== 1'b0) begin n_fail++; $display("FAIL ce_hold_tready: got %b expected 0", tready); end
    n_checks++; if (coeff !== pack5(1, 2, 3, 4, 5)) begin n_fail++; $display("FAIL ce_hold_coeff: got %h expected %h", coeff, pack5(1, 2, 3, 4, 5)); end
    c = 0; n = 0;
    while (c < 200) begin
      ce = (c % 3 == 0);
      @(negedge clk);
      c++;
      if (c == 1) begin
        n_checks++; if (update !== 1'b1 || coeff !== pack5(11, 12, 13, 14, 15)) begin
          n_fail++; $display("FAIL ce_swap: update %b coeff %h expected 1 %h", update, coeff, pack5(11, 12, 13, 14, 15));
        end
      end
      if (settling === 1'b1) n++;
      else break;
    end
    ce = 1'b1;
    n_checks++; if (n != 30) begin n_fail++; $display("FAIL ce_settle_len: got %0d clocks expected 30", n); end
    wait_idle("ce");
  endtask

  task automatic test_short_frame();
    send_word(1'b0, 18'd7, 1'b0);
    err_clr = 1'b1;
    send_word(1'b0, 18'd8, 1'b1);
    err_clr = 1'b0;
    n_checks++; if (err !== 1'b1) begin n_fail++; $display("FAIL short_err: got %b expected 1", err); end
    n_checks++; if (state !== S_IDLE) begin n_fail++; $display("FAIL short_state: got %0d expected %0d", state, S_IDLE); end
    repeat (2) @(negedge clk);
    n_checks++; if (coeff !== pack5(11, 12, 13, 14, 15)) begin n_fail++; $display("FAIL short_coeff: got %h expected %h", coeff, pack5(11, 12, 13, 14, 15)); end
    send_frame(21);
    wait_update("short_next", pack5(21, 22, 23, 24, 25));
    wait_idle("short_next");
    n_checks++; if (err !== 1'b1) begin n_fail++; $display("FAIL short_err_sticky: got %b expected 1", err); end
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL short_err_clr: got %b expected 0", err); end
  endtask

  task automatic test_long_frame();
    for (int i = 0; i < 5; i++) send_word(1'b0, 18'(31 + i), 1'b0);
    n_checks++; if (state !== S_DISCARD || err !== 1'b1) begin n_fail++; $display("FAIL long_discard: state %0d err %b expected %0d 1", state, err, S_DISCARD); end
    send_word(1'b0, 18'd36, 1'b0);
    send_word(1'b0, 18'd37, 1'b1);
    repeat (2) @(negedge clk);
    n_checks++; if (state !== S_IDLE) begin n_fail++; $display("FAIL long_state: got %0d expected %0d", state, S_IDLE); end
    n_checks++; if (coeff !== pack5(21, 22, 23, 24, 25)) begin n_fail++; $display("FAIL long_coeff: got %h expected %h", coeff, pack5(21, 22, 23, 24, 25)); end
    err_clr = 1'b1; @(negedge clk); err_clr = 1'b0;
    send_frame(41);
    wait_update("long_next", pack5(41, 42, 43, 44, 45));
    wait_idle("long_next");
  endtask

  task automatic test_mid_reset();
    for (int i = 0; i < 3; i++) send_word(1'b0, 18'(51 + i), 1'b0);
    rst = 1'b1;
    #1;
    n_checks++; if (tready !== 1'b0) begin n_fail++; $display("FAIL rst_tready: got %b expected 0", tready); end
    @(negedge clk);
    n_checks++; if (coeff !== INIT_A || state !== S_IDLE) begin n_fail++; $display("FAIL rst_frame: coeff %h state %0d expected %h %0d", coeff, state, INIT_A, S_IDLE); end
    rst = 1'b0;
    @(negedge clk);
    send_frame(61);
    wait_update("rst_reload", pack5(61, 62, 63, 64, 65));
    repeat (3) @(negedge clk);
    n_checks++; if (settling !== 1'b1) begin n_fail++; $display("FAIL rst_pre_settle: got %b expected 1", settling); end
    rst = 1'b1;
    @(negedge clk);
    n_checks++; if (settling !== 1'b0 || coeff !== INIT_A) begin n_fail++; $display("FAIL rst_settle: settling %b coeff %h expected 0 %h", settling, coeff, INIT_A); end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    bit done;
    bit settle_seen;
    int upd;
    logic [89:0] e;
    done = 1'b0; settle_seen = 1'b0; upd = 0;
    fork
      begin
        for (int f = 0; f < 4; f++) begin
          exp_q.push_back(pack5(f*16 + 1, f*16 + 2, f*16 + 3, f*16 + 4, f*16 + 5));
          for (int w = 0; w < 5; w++) begin
            repeat ($urandom_range(0, 2)) @(negedge clk);
            send_word(1'b1, 18'(f*16 + w + 1), w == 4);
          end
        end
        repeat (4) @(negedge clk);
        done = 1'b1;
      end
      begin
        while (!done) begin
          @(negedge clk);
          if (b_settling !== 1'b0) settle_seen = 1'b1;
          if (b_update === 1'b1) begin
            upd++;
            n_checks++;
            if (exp_q.size() == 0) begin
              n_fail++; $display("FAIL b2b_extra: unexpected update, coeff %h", b_coeff);
            end else begin
              e = exp_q.pop_front();
              if (b_coeff !== e) begin n_fail++; $display("FAIL b2b_coeff: got %h expected %h", b_coeff, e); end
            end
          end
        end
      end
    join
    n_checks++; if (upd != 4) begin n_fail++; $display("FAIL b2b_count: got %0d updates expected 4", upd); end
    n_checks++; if (settle_seen !== 1'b0) begin n_fail++; $display("FAIL b2b_settling: settling_o asserted with zero flush"); end
    n_checks++; if (b_err !== 1'b0 || b_state !== S_IDLE) begin n_fail++; $display("FAIL b2b_end: err %b state %0d expected 0 %0d", b_err, b_state, S_IDLE); end
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_ce_gated();
    test_short_frame();
    test_long_frame();
    test_mid_reset();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
